// File: rtl/sram_pkg.sv
// Shared encodings and address helper for the SRAM word controller.
// Build option SRAM_CTRL_ADDR_REMAP_EN rebases word addresses to the data segment at DATA_BASE.
package sram_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LO   = 2'd1;
   localparam logic [1:0] ST_HI   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [31:0] DATA_BASE = 32'd1024;
   localparam int          SRAM_DW   = 16;
   localparam int          WAIT_W    = 4;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   // Byte address to 32-bit word index; callers truncate to the SRAM word width,
   // which gives the modulo wrap for free.
   function automatic logic [31:0] word_addr_of(input logic [31:0] byte_addr);
`ifdef SRAM_CTRL_ADDR_REMAP_EN
      return (byte_addr - DATA_BASE) >> 2;
`else
      return byte_addr >> 2;
`endif
   endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Pipeline-side request/response bus of the SRAM word controller.
interface sram_ctrl_if;
   logic        rd_en;
   logic        wr_en;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;

   modport master (output rd_en, output wr_en, output addr, output wdata,
                   input rdata, input ready);
   modport slave  (input rd_en, input wr_en, input addr, input wdata,
                   output rdata, output ready);
endinterface

// File: rtl/sram_wait_cnt.sv
// Per-phase wait counter: counts 0..last while enabled, wraps on terminal count.
module sram_wait_cnt
   import sram_pkg::*;
#(
   parameter int W = WAIT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] last,
   output logic         tc
);

   logic [W-1:0] cnt_q;

   assign tc = en && (cnt_q == last);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= tc ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/sram_ctrl.sv
// 32-bit word access over a 16-bit async SRAM: low half then high half, WAIT_CYCLES each.
// Build option SRAM_CTRL_ADDR_REMAP_EN (see sram_pkg) selects the data-segment address remap.
//
// state   | meaning
// IDLE    | waiting; request accepted combinationally (ready drops at once)
// LO      | low half-word phase, sram_addr LSB = 0
// HI      | high half-word phase, sram_addr LSB = 1
// DONE    | access complete, ready=1, SRAM idle
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   sram_ctrl_if.slave         bus,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [SRAM_DW-1:0] dq_out,
   output logic               dq_oe,
   input  logic [SRAM_DW-1:0] dq_in,
   output logic               sram_we_n,
   output logic               sram_oe_n,
   output logic               sram_ce_n,
   output logic               sram_ub_n,
   output logic               sram_lb_n
);

   localparam int                WA_W = SRAM_AW - 1;
   localparam logic [WAIT_W-1:0] LAST = WAIT_W'(WAIT_CYCLES - 1);

   logic [1:0]         state_q, state_d;
   op_e                op_q;
   logic [WA_W-1:0]    wa_q;
   logic [31:0]        wdata_q;
   logic [31:0]        rdata_q;
   logic [SRAM_DW-1:0] lo_q;
   logic               req, busy, half, tc, wr_phase;

   assign req      = bus.rd_en | bus.wr_en;
   assign busy     = (state_q == ST_LO) || (state_q == ST_HI);
   assign half     = (state_q == ST_HI);
   assign wr_phase = busy && (op_q == OP_WR);

   sram_wait_cnt #(.W(WAIT_W)) u_wait_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (!busy),
      .en   (busy),
      .last (LAST),
      .tc   (tc)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (req) state_d = ST_LO;
         ST_LO:   if (tc)  state_d = ST_HI;
         ST_HI:   if (tc)  state_d = ST_DONE;
         default:          state_d = ST_IDLE;
      endcase
   end

   // The low half is staged in lo_q so rdata only changes when a whole word lands.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_RD;
         wa_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == ST_IDLE) && req) begin
            op_q    <= bus.wr_en ? OP_WR : OP_RD;
            wa_q    <= WA_W'(word_addr_of(bus.addr));
            wdata_q <= bus.wdata;
         end
         if ((op_q == OP_RD) && tc) begin
            if (state_q == ST_LO) begin
               lo_q <= dq_in;
            end else begin
               rdata_q <= {dq_in, lo_q};
            end
         end
      end
   end

   assign sram_addr = busy ? {wa_q, half} : '0;
   assign dq_oe     = wr_phase;
   assign dq_out    = !wr_phase ? '0 : (half ? wdata_q[31:16] : wdata_q[15:0]);
   // we_n released on the last phase cycle to give address/data hold.
   assign sram_we_n = !(wr_phase && !tc);
   assign sram_oe_n = !(busy && (op_q == OP_RD));
   assign sram_ce_n = 1'b0;
   assign sram_ub_n = 1'b0;
   assign sram_lb_n = 1'b0;

   assign bus.ready = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl with a behavioural 16-bit SRAM (W=2, SRAM_AW=18).
module tb_sram_ctrl;

   localparam int W = 2;

   typedef struct {
      bit          wr;
      logic [17:0] sa;
      logic [15:0] d;
   } phase_t;

   typedef struct {
      logic [31:0] rdata;
   } done_t;

   logic        clk;
   logic        rst;
   logic [17:0] sram_addr;
   logic [15:0] dq_out, dq_in;
   logic        dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

   sram_ctrl_if bus ();

   sram_ctrl #(.WAIT_CYCLES(W), .SRAM_AW(18)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .sram_addr (sram_addr),
      .dq_out    (dq_out),
      .dq_oe     (dq_oe),
      .dq_in     (dq_in),
      .sram_we_n (sram_we_n),
      .sram_oe_n (sram_oe_n),
      .sram_ce_n (sram_ce_n),
      .sram_ub_n (sram_ub_n),
      .sram_lb_n (sram_lb_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] mem [0:(1<<18)-1];
   always @(posedge clk) if (rst && !sram_we_n) mem[sram_addr] <= dq_out;
   assign dq_in = sram_oe_n ? 16'h0000 : mem[sram_addr];

   int     total = 0;
   int     bad   = 0;
   phase_t pq[$];
   done_t  doneq[$];
   logic [31:0] cur_rd;
   bit     mon_en;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [17:0] exp_sa(input logic [31:0] a, input bit h);
      logic [31:0] w;
`ifdef SRAM_CTRL_ADDR_REMAP_EN
      w = (a - 32'd1024) >> 2;
`else
      w = a >> 2;
`endif
      return {w[16:0], h};
   endfunction

   task automatic push_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] exp_rd);
      pq.push_back('{wr, exp_sa(a, 1'b0), d[15:0]});
      pq.push_back('{wr, exp_sa(a, 1'b1), d[31:16]});
      if (!wr) cur_rd = exp_rd;
      doneq.push_back('{cur_rd});
   endtask

   task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
      bus.rd_en = rd;
      bus.wr_en = wr;
      bus.addr  = a;
      bus.wdata = d;
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (bus.ready) seen = 1'b1;
      end
      if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_rd, input string name);
      push_access(wr, a, d, exp_rd);
      drive(rd, wr, a, d);
      wait_done(name);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   // Monitor: phase boundaries are seen as the bus becoming active or sram_addr changing.
   bit          in_ph, prev_act, cur_wr;
   logic [17:0] prev_sa;
   int          len, welo, busy_len;

   task automatic start_phase();
      phase_t e;
      if (pq.size() == 0) begin
         chk("unexpected_phase", 32'(sram_addr), 32'h3ffff);
         cur_wr = dq_oe;
      end else begin
         e = pq.pop_front();
         chk("ph_type", 32'(dq_oe), 32'(e.wr));
         chk("ph_addr", 32'(sram_addr), 32'(e.sa));
         if (e.wr) chk("ph_data", 32'(dq_out), 32'(e.d));
         cur_wr = e.wr;
      end
      in_ph = 1'b1;
      len   = 1;
      welo  = sram_we_n ? 0 : 1;
   endtask

   task automatic end_phase();
      chk("ph_len", 32'(len), 32'(W));
      chk("ph_we_lo", 32'(welo), cur_wr ? 32'(W - 1) : 32'd0);
      in_ph = 1'b0;
   endtask

   task automatic complete();
      done_t e;
      if (doneq.size() == 0) begin
         chk("unexpected_done", bus.rdata, 32'hffffffff);
      end else begin
         e = doneq.pop_front();
         chk("busy_len", 32'(busy_len), 32'(2 * W + 1));
         chk("rdata", bus.rdata, e.rdata);
      end
   endtask

   always @(negedge clk) begin
      bit act;
      if (!rst || !mon_en) begin
         in_ph    = 1'b0;
         prev_act = 1'b0;
         busy_len = 0;
      end else begin
         act = dq_oe | ~sram_oe_n;
         if (dq_oe && !sram_oe_n) chk("oe_clash", 32'd1, 32'd0);
         if (act && (!prev_act || sram_addr != prev_sa)) begin
            if (in_ph) end_phase();
            start_phase();
         end else if (act) begin
            len++;
            if (!sram_we_n) welo++;
         end else if (in_ph) begin
            end_phase();
         end
         prev_act = act;
         prev_sa  = sram_addr;
         if (!bus.ready) busy_len++;
         else begin
            if (busy_len > 0) complete();
            busy_len = 0;
         end
      end
   end

   initial begin
      rst    = 1'b0;
      mon_en = 1'b0;
      cur_rd = 32'h0;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_ready", 32'(bus.ready), 32'd1);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
      chk("rst_dq_oe", 32'(dq_oe), 32'd0);
      chk("rst_sram_addr", 32'(sram_addr), 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("tied_sel", {29'd0, sram_ce_n, sram_ub_n, sram_lb_n}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Reset asserted mid-LO of a write
      drive(1'b0, 1'b1, 32'h0000_0500, 32'h1111_2222);
      @(posedge clk); #1;
      @(negedge clk);
      chk("midlo_we_n", 32'(sram_we_n), 32'd0);
      #1;
      rst = 1'b0;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      chk("arst_we_n", 32'(sram_we_n), 32'd1);
      chk("arst_dq_oe", 32'(dq_oe), 32'd0);
      chk("arst_ready", 32'(bus.ready), 32'd1);
      chk("arst_sram_addr", 32'(sram_addr), 32'd0);
      @(negedge clk);
      rst    = 1'b1;
      mon_en = 1'b1;
      @(posedge clk); #1;

      // Write then read back; rdata must survive the intervening write
      access(1'b0, 1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0, "wr400");
      access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF, "rd400");
      access(1'b0, 1'b1, 32'h0000_0404, 32'hCAFE_F00D, 32'h0, "wr404");
      access(1'b1, 1'b0, 32'h0000_0404, 32'h0, 32'hCAFE_F00D, "rd404");

      // Back-to-back reads with rd_en held through DONE
      push_access(1'b0, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF);
      push_access(1'b0, 32'h0000_0400, 32'h0, 32'hDEAD_BEEF);
      drive(1'b1, 1'b0, 32'h0000_0400, 32'h0);
      wait_done("b2b_1");
      @(negedge clk);
      chk("b2b_restart_ready", 32'(bus.ready), 32'd0);
      wait_done("b2b_2");
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 32'h0, 32'h0);

      // rd_en and wr_en together: write wins (remap off: sram_addr 0x4/0x5)
      access(1'b1, 1'b1, 32'h0000_0008, 32'h1357_9BDF, 32'h0, "rdwr8");
      access(1'b1, 1'b0, 32'h0000_0008, 32'h0, 32'h1357_9BDF, "rd8");

      // addr/wdata changed in cycle 2 must not affect the write in flight
      push_access(1'b1, 32'h0000_040C, 32'h0BAD_F00D, 32'h0);
      drive(1'b0, 1'b1, 32'h0000_040C, 32'h0BAD_F00D);
      @(posedge clk); #1;
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 32'h0000_07FC, 32'hFFFF_FFFF);
      wait_done("wr40c");
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      access(1'b1, 1'b0, 32'h0000_040C, 32'h0, 32'h0BAD_F00D, "rd40c");

      repeat (4) @(negedge clk);
      chk("phase_q_empty", 32'(pq.size()), 32'd0);
      chk("done_q_empty", 32'(doneq.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
